// File: rtl/vmask_seq.sv
// Mask-stream sequencer: reads N = ceil(vl/DATA_WIDTH) mask words from the register file,
// optionally ANDs them with v0, trims the tail and emits one registered beat per word.
module vmask_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int VL_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VL_WIDTH-1:0]   vl,
    input  logic                  vm,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rd_req,
    output logic [VL_WIDTH-1:0]   rd_idx,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_vs,
    input  logic [DATA_WIDTH-1:0] rd_v0,
    output logic [DATA_WIDTH-1:0] out_m0,
    output logic                  out_valid,
    output logic                  out_end,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy
);

    localparam int LW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;

    logic [VL_WIDTH-1:0]   vl_r;
    logic [VL_WIDTH-1:0]   n_r;
    logic [VL_WIDTH-1:0]   beat_r;
    logic [VL_WIDTH-1:0]   rd_idx_r;
    logic                  vm_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  pend_r;
    logic                  rd_req_r;
    logic [DATA_WIDTH-1:0] out_m0_r;
    logic                  out_valid_r;
    logic                  out_end_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic                  busy_r;

    logic [VL_WIDTH:0]     vl_round_s;
    logic [VL_WIDTH-1:0]   n_s;
    logic [VL_WIDTH-1:0]   last_idx_s;
    logic [LW-1:0]         rem_s;
    logic                  start_ok_s;
    logic                  accept_s;
    logic                  last_beat_s;
    logic [DATA_WIDTH-1:0] tail_s;
    logic [DATA_WIDTH-1:0] beat_m0_s;

    // Word count, tail trimming and beat data for the current read response
    always_comb begin
        vl_round_s  = {1'b0, vl} + (VL_WIDTH+1)'(DATA_WIDTH - 1);
        n_s         = VL_WIDTH'(vl_round_s >> LW);
        last_idx_s  = n_r - VL_WIDTH'(1);
        rem_s       = vl_r[LW-1:0];
        start_ok_s  = (state_r == IDLE) && start;
        // rd_valid counts only when a request went out on the previous cycle
        accept_s    = rd_valid && pend_r;
        last_beat_s = (beat_r == last_idx_s);
        if (last_beat_s && (rem_s != {LW{1'b0}})) begin
            tail_s = ~({DATA_WIDTH{1'b1}} << rem_s);
        end else begin
            tail_s = {DATA_WIDTH{1'b1}};
        end
        beat_m0_s = rd_vs & (vm_r ? {DATA_WIDTH{1'b1}} : rd_v0) & tail_s;
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (vl != {VL_WIDTH{1'b0}})) begin
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (rd_idx_r == last_idx_s) begin
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            FLUSH: begin
                // Leave only after the end beat has been on the bus for its cycle
                if (out_end_r) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = FLUSH;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Stream context, counters, read requests and registered beat outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            vl_r        <= {VL_WIDTH{1'b0}};
            n_r         <= {VL_WIDTH{1'b0}};
            beat_r      <= {VL_WIDTH{1'b0}};
            rd_idx_r    <= {VL_WIDTH{1'b0}};
            vm_r        <= 1'b0;
            base_r      <= {ADDR_WIDTH{1'b0}};
            pend_r      <= 1'b0;
            rd_req_r    <= 1'b0;
            out_m0_r    <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_end_r   <= 1'b0;
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            if (start_ok_s) begin
                vl_r   <= vl;
                n_r    <= n_s;
                vm_r   <= vm;
                base_r <= base_addr;
                beat_r <= {VL_WIDTH{1'b0}};
            end else if (accept_s) begin
                beat_r <= beat_r + VL_WIDTH'(1);
            end
            rd_req_r <= (state_nx_s == ISSUE);
            rd_idx_r <= ((state_r == ISSUE) && (state_nx_s == ISSUE)) ?
                        rd_idx_r + VL_WIDTH'(1) : {VL_WIDTH{1'b0}};
            pend_r   <= rd_req_r;
            busy_r   <= (state_nx_s != IDLE);
            if (start_ok_s && (vl == {VL_WIDTH{1'b0}})) begin
                out_valid_r <= 1'b1;
                out_end_r   <= 1'b1;
                out_m0_r    <= {DATA_WIDTH{1'b0}};
                out_addr_r  <= base_addr;
            end else if (accept_s) begin
                out_valid_r <= 1'b1;
                out_end_r   <= last_beat_s;
                out_m0_r    <= beat_m0_s;
                out_addr_r  <= base_r;
            end else begin
                out_valid_r <= 1'b0;
                out_end_r   <= 1'b0;
                out_m0_r    <= {DATA_WIDTH{1'b0}};
                out_addr_r  <= {ADDR_WIDTH{1'b0}};
            end
        end
    end

    assign rd_req    = rd_req_r;
    assign rd_idx    = rd_idx_r;
    assign out_m0    = out_m0_r;
    assign out_valid = out_valid_r;
    assign out_end   = out_end_r;
    assign out_addr  = out_addr_r;
    assign busy      = busy_r;

endmodule
